// File: rtl/out_frame_ctrl.sv
// out_frame_ctrl: sequences per-frame engine starts and gates pixels into the output stage.
// Optional STALL_CNT_EN adds a saturating count of back-pressured RUN cycles.
module out_frame_ctrl #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int FB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XB-1:0] cfg_width,
    input  logic [YB-1:0] cfg_height,
    input  logic [FB-1:0] cfg_frames,
    input  logic          start,
    input  logic          abort,
    input  logic          prod_valid,
    output logic          prod_ready,
    output logic          pix_en,
    input  logic          out_inf_busy,
    input  logic          out_done,
    output logic          eng_start,
    output logic [XB-1:0] lat_width,
    output logic [YB-1:0] lat_height,
    output logic [FB-1:0] frame_idx,
    output logic          busy,
    output logic          frame_done,
    output logic          all_done
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [FB-1:0] lat_frames;
    logic [XB-1:0] col;
    logic [YB-1:0] row;
    logic last_pix, last_frame, col_end;
    always_comb begin
        pix_en     = state == RUN && prod_valid && !out_inf_busy;
        prod_ready = pix_en;
        eng_start  = state == LOAD;
        busy       = state != IDLE;
        frame_done = state == DONE;
        col_end    = col == lat_width;
        last_pix   = pix_en && col_end && row == lat_height;
        // cfg_frames of 0 runs a single frame, same as 1
        last_frame = frame_idx == (lat_frames == '0 ? '0 : lat_frames - FB'(1));
        all_done   = frame_done && last_frame;
        state_nx   = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (last_pix) state_nx = DRAIN;
            DRAIN:   if (out_done) state_nx = DONE;
            DONE:    state_nx = last_frame ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_width  <= '0;
            lat_height <= '0;
            lat_frames <= '0;
            frame_idx  <= '0;
            col        <= '0;
            row        <= '0;
        end else begin
            state <= state_nx;
            if (abort) begin
                frame_idx <= '0;
                col       <= '0;
                row       <= '0;
            end else begin
                if (state == IDLE && start) begin
                    lat_width  <= cfg_width;
                    lat_height <= cfg_height;
                    lat_frames <= cfg_frames;
                    frame_idx  <= '0;
                end
                if (state == LOAD) begin
                    col <= '0;
                    row <= '0;
                end
                if (pix_en) begin
                    col <= col_end ? '0 : col + XB'(1);
                    if (col_end && row != lat_height) row <= row + YB'(1);
                end
                if (state == DONE && !last_frame) frame_idx <= frame_idx + FB'(1);
            end
        end
    end
`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start && !abort)) stall_cnt <= '0;
        else if (state == RUN && prod_valid && out_inf_busy && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
